// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Write-back arbiter for the register file's single write port. NUM_REQ
//   producers present writes over valid/ready. At most one is granted per cycle,
//   in round-robin order. The granted write is registered once and driven to
//   the regfile write port. The optional read-path forwarding is enabled with
//   the macro WB_FORWARD_EN.
//
//   Ports
//     clk, rst_n            clock (rising edge), asynchronous active-low reset
//     req_valid/req_ready   per-requester handshake; ready is combinational, one-hot or zero
//     req_addr/req_data     flattened per-requester destination register / write data
//     rf_writeReg/Data/write  registered regfile write port
//     rd_addr1/2            read addresses (also drive regfile readReg1/2)
//     rf_rdata1/2           regfile asynchronous read data
//     rd_data1/2            read data to the datapath (forwarded when WB_FORWARD_EN)
//     wr_count              committed write count (wraps at 2^32)

// One read port's bypass from the in-flight write-port register.
module wb_fwd_port #(
  parameter int DATAWIDTH = 32
) (
  input  logic                 i_rf_write,
  input  logic [4:0]           i_rf_waddr,
  input  logic [DATAWIDTH-1:0] i_rf_wdata,
  input  logic [4:0]           i_rd_addr,
  input  logic [DATAWIDTH-1:0] i_rf_rdata,
  output logic [DATAWIDTH-1:0] o_rd_data
);
`ifdef WB_FORWARD_EN
  // A dropped address-0 write never raises i_rf_write, so address 0 is never bypassed.
  assign o_rd_data = (i_rf_write && (i_rd_addr == i_rf_waddr)) ? i_rf_wdata : i_rf_rdata;
`else
  logic w_unused;
  assign w_unused  = ^{i_rf_write, i_rf_waddr, i_rf_wdata, i_rd_addr};
  assign o_rd_data = i_rf_rdata;
`endif
endmodule

module regfile_wb_arbiter #(
  parameter int DATAWIDTH = 32,
  parameter int NUM_REQ   = 2,
  parameter int DROP_ZERO = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [5*NUM_REQ-1:0]           req_addr,
  input  logic [DATAWIDTH*NUM_REQ-1:0]   req_data,
  output logic [4:0]                     rf_writeReg,
  output logic [DATAWIDTH-1:0]           rf_writeData,
  output logic                           rf_write,
  input  logic [4:0]                     rd_addr1,
  input  logic [4:0]                     rd_addr2,
  input  logic [DATAWIDTH-1:0]           rf_rdata1,
  input  logic [DATAWIDTH-1:0]           rf_rdata2,
  output logic [DATAWIDTH-1:0]           rd_data1,
  output logic [DATAWIDTH-1:0]           rd_data2,
  output logic [31:0]                    wr_count
);
  localparam int PW = (NUM_REQ > 2) ? 2 : 1;

  logic [PW-1:0]        r_ptr;
  logic                 r_we;
  logic [4:0]           r_waddr;
  logic [DATAWIDTH-1:0] r_wdata;
  logic [31:0]          r_cnt;

  logic [NUM_REQ-1:0]   w_gnt;
  logic                 w_gnt_vld;
  logic [PW-1:0]        w_gnt_idx;
  logic [PW:0]          w_sum;
  logic [4:0]           w_gnt_addr;
  logic [DATAWIDTH-1:0] w_gnt_data;
  logic [PW-1:0]        w_ptr_nxt;
  logic                 w_drop;

  // Rotating priority search: first valid at or after r_ptr, wrapping at NUM_REQ.
  // rst_n gates the grant so nothing is acknowledged while in reset.
  always_comb begin
    w_gnt      = '0;
    w_gnt_vld  = 1'b0;
    w_gnt_idx  = '0;
    w_sum      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, r_ptr} + (PW+1)'(k);
      if (w_sum >= (PW+1)'(NUM_REQ)) w_sum = w_sum - (PW+1)'(NUM_REQ);
      if (!w_gnt_vld && rst_n && req_valid[w_sum[PW-1:0]]) begin
        w_gnt_vld              = 1'b1;
        w_gnt_idx              = w_sum[PW-1:0];
        w_gnt[w_sum[PW-1:0]]   = 1'b1;
      end
    end
  end

  assign req_ready  = w_gnt;
  assign w_gnt_addr = req_addr[5*w_gnt_idx +: 5];
  assign w_gnt_data = req_data[DATAWIDTH*w_gnt_idx +: DATAWIDTH];
  assign w_ptr_nxt  = (w_gnt_idx == PW'(NUM_REQ-1)) ? '0 : w_gnt_idx + 1'b1;
  assign w_drop     = (DROP_ZERO != 0) && (w_gnt_addr == 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr   <= '0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_cnt   <= '0;
    end else begin
      // Dropped address-0 writes still complete the handshake and rotate priority.
      r_we <= w_gnt_vld && !w_drop;
      if (w_gnt_vld) begin
        r_ptr   <= w_ptr_nxt;
        r_waddr <= w_gnt_addr;
        r_wdata <= w_gnt_data;
      end
      if (r_we) r_cnt <= r_cnt + 32'd1;
    end
  end

  assign rf_write     = r_we;
  assign rf_writeReg  = r_waddr;
  assign rf_writeData = r_wdata;
  assign wr_count     = r_cnt;

  logic [1:0][4:0]           w_rd_addr;
  logic [1:0][DATAWIDTH-1:0] w_rf_rdata;
  logic [1:0][DATAWIDTH-1:0] w_rd_data;

  assign w_rd_addr  = {rd_addr2, rd_addr1};
  assign w_rf_rdata = {rf_rdata2, rf_rdata1};

  for (genvar p = 0; p < 2; p++) begin : g_fwd
    wb_fwd_port #(.DATAWIDTH(DATAWIDTH)) u_fwd (
      .i_rf_write (r_we),
      .i_rf_waddr (r_waddr),
      .i_rf_wdata (r_wdata),
      .i_rd_addr  (w_rd_addr[p]),
      .i_rf_rdata (w_rf_rdata[p]),
      .o_rd_data  (w_rd_data[p])
    );
  end

  assign rd_data1 = w_rd_data[0];
  assign rd_data2 = w_rd_data[1];
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
  localparam int DW = 32;
  localparam int NR = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NR-1:0] req_valid;
  logic [NR-1:0] req_ready;
  logic [5*NR-1:0]  req_addr;
  logic [DW*NR-1:0] req_data;
  logic [4:0]    rf_writeReg;
  logic [DW-1:0] rf_writeData;
  logic          rf_write;
  logic [4:0]    rd_addr1, rd_addr2;
  logic [DW-1:0] rf_rdata1, rf_rdata2, rd_data1, rd_data2;
  logic [31:0]   wr_count;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] tb_rf [32];

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.DATAWIDTH(DW), .NUM_REQ(NR), .DROP_ZERO(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .rf_writeReg(rf_writeReg), .rf_writeData(rf_writeData), .rf_write(rf_write),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .rd_data1(rd_data1), .rd_data2(rd_data2),
    .wr_count(wr_count)
  );

  // Register file model: commits on the rising edge when rf_write is high.
  initial for (int i = 0; i < 32; i++) tb_rf[i] = 32'hF000_0000 | i;
  always @(posedge clk) if (rf_write) tb_rf[rf_writeReg] <= rf_writeData;
  assign rf_rdata1 = tb_rf[rd_addr1];
  assign rf_rdata2 = tb_rf[rd_addr2];

  task automatic set_req(input int i, input logic [4:0] a, input logic [DW-1:0] d);
    req_addr[5*i +: 5]   = a;
    req_data[DW*i +: DW] = d;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_valid = 2'b11; set_req(0, 5'd1, 32'h1); set_req(1, 5'd2, 32'h2);
    rd_addr1 = 5'd0; rd_addr2 = 5'd0;
    @(negedge clk); #1;
    chk("rst_ready", req_ready, 2'b00);
    chk("rst_write", rf_write, 1'b0);
    chk("rst_reg",   rf_writeReg, 5'd0);
    chk("rst_data",  rf_writeData, 32'd0);
    chk("rst_count", wr_count, 32'd0);
    req_valid = 2'b00;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_single;
    req_valid = 2'b01; set_req(0, 5'd5, 32'hDEADBEEF); #1;
    chk("single_ready", req_ready, 2'b01);
    @(negedge clk); req_valid = 2'b00; #1;
    chk("single_write", rf_write, 1'b1);
    chk("single_reg",   rf_writeReg, 5'd5);
    chk("single_data",  rf_writeData, 32'hDEADBEEF);
    @(negedge clk); #1;
    chk("single_idle",  rf_write, 1'b0);
    chk("single_count", wr_count, 32'd1);
    chk("single_commit", tb_rf[5], 32'hDEADBEEF);
  endtask

  // Pointer is 1 on entry; requester 1 writes address 0.
  task automatic test_zero_drop;
    req_valid = 2'b10; set_req(1, 5'd0, 32'hFF); #1;
    chk("zero_ready", req_ready, 2'b10);
    @(negedge clk); req_valid = 2'b00; #1;
    chk("zero_nowrite", rf_write, 1'b0);
    @(negedge clk); #1;
    chk("zero_count", wr_count, 32'd1);
  endtask

  // Pointer is 0 on entry: grant order 0,1,0,1.
  task automatic test_round_robin;
    logic [1:0] exp_rdy [4];
    logic [4:0] exp_reg [4];
    exp_rdy[0] = 2'b01; exp_rdy[1] = 2'b10; exp_rdy[2] = 2'b01; exp_rdy[3] = 2'b10;
    exp_reg[0] = 5'd1;  exp_reg[1] = 5'd2;  exp_reg[2] = 5'd1;  exp_reg[3] = 5'd2;
    req_valid = 2'b11; set_req(0, 5'd1, 32'h100); set_req(1, 5'd2, 32'h200);
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("rr_ready%0d", c), req_ready, exp_rdy[c]);
      if (c > 0) begin
        chk($sformatf("rr_write%0d", c), rf_write, 1'b1);
        chk($sformatf("rr_reg%0d", c), rf_writeReg, exp_reg[c-1]);
      end
      @(negedge clk);
    end
    req_valid = 2'b00; #1;
    chk("rr_reg3", rf_writeReg, exp_reg[3]);
    chk("rr_data3", rf_writeData, 32'h200);
    @(negedge clk); #1;
    chk("rr_count", wr_count, 32'd5);
  endtask

  task automatic test_same_addr;
    // Move pointer to 1 with a lone requester-0 write.
    req_valid = 2'b01; set_req(0, 5'd10, 32'h33);
    @(negedge clk);
    req_valid = 2'b11; set_req(0, 5'd7, 32'h11); set_req(1, 5'd7, 32'h22); #1;
    chk("same_first", req_ready, 2'b10);
    @(negedge clk); req_valid = 2'b01; #1;
    chk("same_second", req_ready, 2'b01);
    chk("same_wdata1", rf_writeData, 32'h22);
    @(negedge clk); req_valid = 2'b00; #1;
    chk("same_wdata2", rf_writeData, 32'h11);
    chk("same_wreg2", rf_writeReg, 5'd7);
    @(negedge clk); #1;
    chk("same_final", tb_rf[7], 32'h11);
    chk("same_count", wr_count, 32'd8);
  endtask

  task automatic test_forward;
    req_valid = 2'b01; set_req(0, 5'd3, 32'hABCD);
    @(negedge clk); req_valid = 2'b00; rd_addr1 = 5'd3; rd_addr2 = 5'd4; #1;
    chk("fwd_write", rf_write, 1'b1);
`ifdef WB_FORWARD_EN
    chk("fwd_rd1", rd_data1, 32'hABCD);
`else
    chk("fwd_rd1", rd_data1, 32'hF000_0003);
`endif
    chk("fwd_rd2", rd_data2, 32'hF000_0004);
    @(negedge clk); #1;
    chk("fwd_rd1_after", rd_data1, 32'hABCD);
  endtask

  task automatic test_reset_mid;
    req_valid = 2'b01; set_req(0, 5'd12, 32'h55);
    @(negedge clk); #1;
    chk("mid_pending", rf_write, 1'b1);
    rst_n = 1'b0; #1;
    chk("mid_write", rf_write, 1'b0);
    chk("mid_reg",   rf_writeReg, 5'd0);
    chk("mid_data",  rf_writeData, 32'd0);
    chk("mid_count", wr_count, 32'd0);
    chk("mid_ready", req_ready, 2'b00);
    @(negedge clk); req_valid = 2'b00; rst_n = 1'b1;
    @(negedge clk); #1;
    chk("mid_nowrite", rf_write, 1'b0);
    chk("mid_rf12", tb_rf[12], 32'hF000_000C);
  endtask

  initial begin
    req_addr = '0; req_data = '0;
    test_reset;
    test_single;
    test_zero_drop;
    test_round_robin;
    test_same_addr;
    test_forward;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Write-back arbiter and sequencer for the 32-entry register file's single write port. It accepts write requests from NUM_REQ producers (e.g. ALU, load unit, multiply unit) over valid/ready handshakes and grants at most one per cycle in round-robin order. It drives a registered write port into regfile and optionally forwards in-flight write data onto the register file's two asynchronous read paths.

Parameters:
DATAWIDTH, 32, width of write data; matches regfile DATAWIDTH.
NUM_REQ, 2, number of requesters; legal range 2..4.
DROP_ZERO, 1, when 1, a granted write to address 0 completes its handshake but never asserts rf_write.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
req_valid  input  NUM_REQ  per-requester write request valid.
req_ready  output  NUM_REQ  per-requester grant; combinational, one-hot or zero.
req_addr  input  5*NUM_REQ  flattened destination register; requester i occupies [5i+4:5i].
req_data  input  DATAWIDTH*NUM_REQ  flattened write data; requester i occupies slice i.
rf_writeReg  output  5  to regfile writeReg.
rf_writeData  output  DATAWIDTH  to regfile writeData.
rf_write  output  1  to regfile write.
rd_addr1  input  5  read address 1, also driven to regfile readReg1.
rd_addr2  input  5  read address 2, also driven to regfile readReg2.
rf_rdata1  input  DATAWIDTH  regfile readData1.
rf_rdata2  input  DATAWIDTH  regfile readData2.
rd_data1  output  DATAWIDTH  read data 1 to the datapath.
rd_data2  output  DATAWIDTH  read data 2 to the datapath.
wr_count  output  32  number of committed writes (rf_write pulses).

Behaviour:
- Reset (rst_n low, asynchronous): rf_write=0, rf_writeReg=0, rf_writeData=0, wr_count=0, RR pointer=0. req_ready is 0 while rst_n is low.
- Handshake: transfer on req_valid[i] & req_ready[i]. Each requester must hold addr and data stable while valid and not ready. req_ready[i] must not depend on req_ready of any other requester.
- Arbitration: among valid requesters, grant the first at or after the pointer, searching upward with wrap from NUM_REQ-1 to 0. On a grant to i, the pointer becomes (i+1) mod NUM_REQ; with no grant, the pointer holds.
- Write-port stage is a single register with 1-cycle latency. A grant at edge N produces rf_write=1 with that addr/data during cycle N+1, and regfile commits at edge N+1. With no grant, rf_write=0 the next cycle. The write port never stalls, so one grant is possible every cycle; sustained throughput is 1 write/cycle.
- DROP_ZERO=1 and granted addr==0: handshake completes, rf_write=0 next cycle, wr_count unchanged, pointer still advances.
- Same address from two requesters in one cycle: the RR winner writes first, the loser next cycle. Final regfile value equals the later-granted data.
- wr_count increments by 1 on every cycle with rf_write=1 and wraps at 2^32-1 to 0.
- Reset mid-operation: a pending registered write is discarded with no rf_write pulse. Requesters re-present after reset.

Optional Feature:
Macro WB_FORWARD_EN.
- Defined: rd_dataK = rf_writeData when rf_write=1 and rd_addrK==rf_writeReg, otherwise rf_rdataK. Address 0 is never forwarded when DROP_ZERO=1, because rf_write is already 0 in that case. Forwarding is purely combinational.
- Undefined: rd_dataK = rf_rdataK unconditionally, and software/control must insert one bubble.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with rf_write=1 pending -> all outputs 0 immediately; after release, no write pulse occurs.
- Single requester: req0 valid addr=5 data=0xDEADBEEF -> req_ready[0]=1 same cycle; next cycle rf_write=1, rf_writeReg=5, rf_writeData=0xDEADBEEF; wr_count=1.
- Round-robin: both valid continuously for 4 cycles (NUM_REQ=2), addr 1/2 -> grant order 0,1,0,1; rf_writeReg sequence 1,2,1,2 one cycle delayed.
- Same address: req0 addr=7 data=0x11 and req1 addr=7 data=0x22 simultaneously with pointer=1 -> req1 granted first, then req0; regfile[7] ends 0x11.
- Zero drop: req1 addr=0 data=0xFF -> ready=1, no rf_write, wr_count unchanged, pointer advances to 0.
- Forwarding (WB_FORWARD_EN): rf_write=1 addr=3 data=0xABCD with rd_addr1=3, rd_addr2=4 -> rd_data1=0xABCD, rd_data2=rf_rdata2. Without the macro, rd_data1=rf_rdata1.
